// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - N-direction FORWARD/RIGHT/LEFT/OFF phase sequencer with countdowns
// Optional per-tick prescaler enabled by defining TICK_PRESCALE_EN.
module traffic_phase_sequencer #(
  parameter int NUM_DIR   = 2,
  parameter int CNT_W     = 8,
  parameter int DEF_FWD   = 15,
  parameter int DEF_RIGHT = 10,
  parameter int DEF_LEFT  = 10,
  parameter int DEF_OFF   = 3,
  parameter int MAX_DUR   = 99,
  parameter int TICK_DIV  = 50,
  parameter int DIR_W     = ($clog2(NUM_DIR) > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     cfg_en,
  input  logic [1:0]               cfg_sel,
  input  logic                     cfg_inc,
  input  logic                     cfg_dec,
  output logic [2*NUM_DIR-1:0]     phase,
  output logic [CNT_W*NUM_DIR-1:0] countdown,
  output logic [DIR_W-1:0]         active_dir
);

  localparam logic [1:0] PH_OFF   = 2'd0;
  localparam logic [1:0] PH_LEFT  = 2'd1;
  localparam logic [1:0] PH_FWD   = 2'd2;
  localparam logic [1:0] PH_RIGHT = 2'd3;
  localparam int WW = CNT_W + DIR_W + 3;
  localparam logic [WW-1:0] SAT = WW'({CNT_W{1'b1}});

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               ph_q, ph_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DIR_W-1:0]         dir_q, dir_d;
  logic [CNT_W-1:0]         dur_q [4];
  logic [CNT_W-1:0]         dur_d [4];
  logic                     inc_q, dec_q, en_q;
  logic [2*NUM_DIR-1:0]     phase_q, phase_d;
  logic [CNT_W*NUM_DIR-1:0] cd_q, cd_d;
  logic                     inc_rise, dec_rise, en_fall, clear;
  logic [WW-1:0]            period, tail, rem, val;
  int                       k;
  logic                     tick;

  assign inc_rise = cfg_inc & ~inc_q;
  assign dec_rise = cfg_dec & ~dec_q;
  assign en_fall  = en_q & ~cfg_en;
  assign clear    = hold | en_fall;

`ifdef TICK_PRESCALE_EN
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    if (clear) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dur_d   = dur_q;
    // Adjust runs regardless of hold; a new value is only seen at the next load of that phase.
    if (cfg_en && (inc_rise ^ dec_rise)) begin
      if (inc_rise && dur_q[cfg_sel] < CNT_W'(MAX_DUR))
        dur_d[cfg_sel] = dur_q[cfg_sel] + 1'b1;
      else if (dec_rise && dur_q[cfg_sel] > CNT_W'(1))
        dur_d[cfg_sel] = dur_q[cfg_sel] - 1'b1;
    end
    if (clear) begin
      state_d = IDLE;
      ph_d    = PH_OFF;
      cnt_d   = '0;
      dir_d   = '0;
    end else if (tick) begin
      if (state_q == IDLE) begin
        state_d = RUN;
        ph_d    = PH_FWD;
        cnt_d   = dur_q[PH_FWD];
        dir_d   = '0;
      end else if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (ph_q)
          PH_FWD:   ph_d = PH_RIGHT;
          PH_RIGHT: ph_d = PH_LEFT;
          PH_LEFT:  ph_d = PH_OFF;
          default: begin
            ph_d  = PH_FWD;
            dir_d = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;
          end
        endcase
        cnt_d = dur_q[ph_d];
      end
    end
  end

  // Waiting directions see ticks until their own FORWARD: rest of the active cycle plus k full periods.
  always_comb begin
    phase_d = '0;
    cd_d    = '0;
    period  = WW'(dur_d[0]) + WW'(dur_d[1]) + WW'(dur_d[2]) + WW'(dur_d[3]);
    case (ph_d)
      PH_FWD:   tail = WW'(dur_d[PH_RIGHT]) + WW'(dur_d[PH_LEFT]) + WW'(dur_d[PH_OFF]);
      PH_RIGHT: tail = WW'(dur_d[PH_LEFT]) + WW'(dur_d[PH_OFF]);
      PH_LEFT:  tail = WW'(dur_d[PH_OFF]);
      default:  tail = '0;
    endcase
    rem = WW'(cnt_d) + tail;
    k   = 0;
    val = '0;
    if (state_d == RUN) begin
      for (int d = 0; d < NUM_DIR; d++) begin
        if (DIR_W'(d) == dir_d) begin
          phase_d[2*d +: 2]       = ph_d;
          cd_d[CNT_W*d +: CNT_W] = cnt_d;
        end else begin
          k = d - int'(dir_d) - 1;
          if (k < 0) k = k + NUM_DIR;
          val = rem + WW'(k) * period;
          cd_d[CNT_W*d +: CNT_W] = (val > SAT) ? {CNT_W{1'b1}} : val[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ph_q         <= PH_OFF;
      cnt_q        <= '0;
      dir_q        <= '0;
      dur_q[PH_OFF]   <= CNT_W'(DEF_OFF);
      dur_q[PH_LEFT]  <= CNT_W'(DEF_LEFT);
      dur_q[PH_FWD]   <= CNT_W'(DEF_FWD);
      dur_q[PH_RIGHT] <= CNT_W'(DEF_RIGHT);
      inc_q        <= cfg_inc;
      dec_q        <= cfg_dec;
      en_q         <= cfg_en;
      phase_q      <= '0;
      cd_q         <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dur_q   <= dur_d;
      inc_q   <= cfg_inc;
      dec_q   <= cfg_dec;
      en_q    <= cfg_en;
      phase_q <= phase_d;
      cd_q    <= cd_d;
    end
  end

  assign phase      = phase_q;
  assign countdown  = cd_q;
  assign active_dir = dir_q;

endmodule
